// File: rtl/bp_be_issue_buffer_pkg.sv
// Shared defaults and an elaboration helper for the replayable issue buffer.
package bp_be_issue_buffer_pkg;

   localparam int issue_pkt_width_gp = 64;
   localparam int issue_els_gp       = 4;

   // Depth must be a power of two so the pointer LSBs index storage directly.
   function automatic logic is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/bp_be_issue_buffer_if.sv
// Handshake bundle between FE queue, issue buffer and BE scheduler.
interface bp_be_issue_buffer_if
   import bp_be_issue_buffer_pkg::*;
#(
   parameter int pkt_width_p = issue_pkt_width_gp,
   parameter int els_p       = issue_els_gp
);

   localparam int ptr_width_lp = $clog2(els_p);

   logic                   enq_v;
   logic                   enq_ready;
   logic [pkt_width_p-1:0] enq_pkt;
   logic                   deq_v;
   logic [pkt_width_p-1:0] deq_pkt;
   logic                   deq_yumi;
   logic                   cmt_v;
   logic                   roll;
   logic                   clr;
   logic [ptr_width_lp:0]  issued_cnt;
   logic [ptr_width_lp:0]  occupancy;

   modport master (
      output enq_v, enq_pkt, deq_yumi, cmt_v, roll, clr,
      input  enq_ready, deq_v, deq_pkt, issued_cnt, occupancy
   );

   modport slave (
      input  enq_v, enq_pkt, deq_yumi, cmt_v, roll, clr,
      output enq_ready, deq_v, deq_pkt, issued_cnt, occupancy
   );

endinterface

// File: rtl/bp_be_issue_buffer_ptr.sv
// Wrap-bit pointer: clear beats load beats increment.
module bp_be_issue_buffer_ptr #(
   parameter int width_p = 3
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clr_i,
   input  logic               inc_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic [width_p-1:0] ptr_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         ptr_o <= '0;
      end else if (load_i) begin
         ptr_o <= load_val_i;
      end else if (inc_i) begin
         ptr_o <= ptr_o + width_p'(1);
      end
   end

endmodule

// File: rtl/bp_be_issue_buffer.sv
// Replayable circular issue buffer with write, speculative read and commit pointers.
module bp_be_issue_buffer
   import bp_be_issue_buffer_pkg::*;
#(
   parameter int pkt_width_p = issue_pkt_width_gp,
   parameter int els_p       = issue_els_gp,
   localparam int ptr_width_lp = $clog2(els_p)
) (
   input  logic clk_i,
   input  logic reset_i,
   bp_be_issue_buffer_if.slave io
);

   if (!is_pow2(els_p)) begin : g_els_check
      $error("bp_be_issue_buffer: els_p must be a power of two >= 2");
   end

   localparam logic [ptr_width_lp:0] full_cnt_lp = (ptr_width_lp + 1)'(els_p);

   logic [pkt_width_p-1:0] mem [els_p];
   logic [ptr_width_lp:0]  wptr, rptr, cptr, cptr_next;
   logic                   full, enq_fire, issue_fire, cmt_fire;

   assign full       = (wptr - cptr) == full_cnt_lp;
   assign enq_fire   = io.enq_v & ~full;
   assign issue_fire = io.deq_yumi & io.deq_v & ~io.roll;
   assign cmt_fire   = io.cmt_v & (rptr != cptr);
   // A roll that coincides with a commit must skip the entry retiring now.
   assign cptr_next  = cptr + (ptr_width_lp + 1)'(cmt_fire);

   bp_be_issue_buffer_ptr #(.width_p(ptr_width_lp + 1)) wptr_ctr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (io.clr),
      .inc_i      (enq_fire),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (wptr)
   );

   bp_be_issue_buffer_ptr #(.width_p(ptr_width_lp + 1)) rptr_ctr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (io.clr),
      .inc_i      (issue_fire),
      .load_i     (io.roll),
      .load_val_i (cptr_next),
      .ptr_o      (rptr)
   );

   bp_be_issue_buffer_ptr #(.width_p(ptr_width_lp + 1)) cptr_ctr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (io.clr),
      .inc_i      (cmt_fire),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (cptr)
   );

   // Storage is intentionally unreset; deq_v gates its visibility.
   always_ff @(posedge clk_i) begin
      if (enq_fire && !io.clr && !reset_i) begin
         mem[wptr[ptr_width_lp-1:0]] <= io.enq_pkt;
      end
   end

   assign io.enq_ready  = ~full;
   assign io.deq_v      = (rptr != wptr);
   assign io.deq_pkt    = mem[rptr[ptr_width_lp-1:0]];
   assign io.issued_cnt = rptr - cptr;
   assign io.occupancy  = wptr - cptr;

   yumi_requires_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      io.deq_yumi |-> io.deq_v);

   commit_requires_issued: assert property (@(posedge clk_i) disable iff (reset_i)
      io.cmt_v |-> (rptr != cptr));

endmodule

// File: tb/tb_bp_be_issue_buffer.sv
// Directed scoreboard bench for the replayable issue buffer (els_p=4).
module tb_bp_be_issue_buffer;

   localparam int PW = 64;

   localparam logic [PW-1:0] PA = 64'hA000_0000_0000_000A;
   localparam logic [PW-1:0] PB = 64'hB000_0000_0000_000B;
   localparam logic [PW-1:0] PC = 64'hC000_0000_0000_000C;
   localparam logic [PW-1:0] PD = 64'hD000_0000_0000_000D;
   localparam logic [PW-1:0] PE = 64'hE000_0000_0000_000E;
   localparam logic [PW-1:0] PW0 = 64'h0000_0000_0000_0100;
   localparam logic [PW-1:0] PF0 = 64'hF000_0000_0000_00F0;
   localparam logic [PW-1:0] PX = 64'h5555_0000_0000_5555;
   localparam logic [PW-1:0] PG0 = 64'h6000_0000_0000_0060;
   localparam logic [PW-1:0] PH = 64'h7777_0000_0000_7777;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [PW-1:0] expQ [$];

   bp_be_issue_buffer_if #(.pkt_width_p(PW), .els_p(4)) io ();

   bp_be_issue_buffer #(.pkt_width_p(PW), .els_p(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .io      (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   // Scoreboard monitor: every accepted issue must match the next expected packet.
   always @(negedge clk) begin
      if (!rst && !io.clr && !io.roll && io.deq_yumi && io.deq_v) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL issue_order got %h required <nothing>", io.deq_pkt);
         end else begin
            logic [PW-1:0] expPkt;
            expPkt = expQ.pop_front();
            if (io.deq_pkt !== expPkt) begin
               errors++;
               $display("[TB] FAIL issue_order got %h required %h", io.deq_pkt, expPkt);
            end
         end
      end
   end

   task automatic applyStimulus(input logic enq, input logic [PW-1:0] pkt, input logic yumi,
                                input logic cmt, input logic roll, input logic clr,
                                input logic rstv);
      io.enq_v    = enq;
      io.enq_pkt  = pkt;
      io.deq_yumi = yumi;
      io.cmt_v    = cmt;
      io.roll     = roll;
      io.clr      = clr;
      rst         = rstv;
      @(posedge clk);
      #1;
      io.enq_v    = 1'b0;
      io.deq_yumi = 1'b0;
      io.cmt_v    = 1'b0;
      io.roll     = 1'b0;
      io.clr      = 1'b0;
      rst         = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic expDeqV, input logic expReady,
                              input int expIssued, input int expOcc, input logic chkPkt,
                              input logic [PW-1:0] expPkt);
      checks++;
      if (io.deq_v !== expDeqV) begin
         errors++;
         $display("[TB] FAIL %s deq_v got %0b required %0b", name, io.deq_v, expDeqV);
      end
      checks++;
      if (io.enq_ready !== expReady) begin
         errors++;
         $display("[TB] FAIL %s enq_ready got %0b required %0b", name, io.enq_ready, expReady);
      end
      checks++;
      if (io.issued_cnt !== 3'(expIssued)) begin
         errors++;
         $display("[TB] FAIL %s issued_cnt got %0d required %0d", name, io.issued_cnt, expIssued);
      end
      checks++;
      if (io.occupancy !== 3'(expOcc)) begin
         errors++;
         $display("[TB] FAIL %s occupancy got %0d required %0d", name, io.occupancy, expOcc);
      end
      if (chkPkt) begin
         checks++;
         if (io.deq_pkt !== expPkt) begin
            errors++;
            $display("[TB] FAIL %s deq_pkt got %h required %h", name, io.deq_pkt, expPkt);
         end
      end
   endtask

   task automatic enq(input logic [PW-1:0] pkt);
      applyStimulus(1'b1, pkt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic issue(input logic [PW-1:0] expPkt, input logic cmt);
      expQ.push_back(expPkt);
      applyStimulus(1'b0, '0, 1'b1, cmt, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic commit();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic roll();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      io.enq_v = 1'b0; io.enq_pkt = '0; io.deq_yumi = 1'b0;
      io.cmt_v = 1'b0; io.roll = 1'b0; io.clr = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      // Fill to full; the fifth request must be dropped.
      enq(PA);
      checkOutput("enq_visible", 1'b1, 1'b1, 0, 1, 1'b1, PA);
      enq(PB);
      enq(PC);
      enq(PD);
      checkOutput("full", 1'b1, 1'b0, 0, 4, 1'b1, PA);
      enq(PE);
      checkOutput("enq_when_full", 1'b1, 1'b0, 0, 4, 1'b1, PA);

      issue(PA, 1'b0);
      checkOutput("issue1", 1'b1, 1'b0, 1, 4, 1'b1, PB);
      issue(PB, 1'b0);
      checkOutput("issue2", 1'b1, 1'b0, 2, 4, 1'b1, PC);
      commit();
      checkOutput("commit1", 1'b1, 1'b1, 1, 3, 1'b1, PC);

      // Roll back to B and replay B, C, D.
      issue(PC, 1'b0);
      checkOutput("issue3", 1'b1, 1'b1, 2, 3, 1'b1, PD);
      roll();
      checkOutput("roll", 1'b1, 1'b1, 0, 3, 1'b1, PB);
      issue(PB, 1'b0);
      issue(PC, 1'b0);
      issue(PD, 1'b0);
      checkOutput("reissue", 1'b0, 1'b1, 3, 3, 1'b0, '0);
      enq(PE);
      checkOutput("enq_e", 1'b1, 1'b0, 3, 4, 1'b1, PE);

      // Roll + commit + yumi together: commit retires B, yumi is dropped.
      roll();
      checkOutput("roll2", 1'b1, 1'b0, 0, 4, 1'b1, PB);
      issue(PB, 1'b0);
      issue(PC, 1'b0);
      checkOutput("reissue_bc", 1'b1, 1'b0, 2, 4, 1'b1, PD);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("roll_cmt_yumi", 1'b1, 1'b1, 0, 3, 1'b1, PC);

      issue(PC, 1'b0);
      issue(PD, 1'b1);
      issue(PE, 1'b1);
      commit();
      checkOutput("drained", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      // Pipelined enq/issue/commit stream crossing both wrap points.
      for (int i = 0; i < 12; i++) begin
         if (i >= 1 && i <= 10) expQ.push_back(PW0 + PW'(i - 1));
         applyStimulus(i < 10, PW0 + PW'(i), (i >= 1 && i <= 10), (i >= 2),
                       1'b0, 1'b0, 1'b0);
         if (i >= 2 && i <= 9)
            checkOutput("wrap_steady", 1'b1, 1'b1, 1, 2, 1'b1, PW0 + PW'(i));
      end
      checkOutput("wrap_end", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      enq(PF0);
      enq(PF0 + 1);
      enq(PF0 + 2);
      checkOutput("fill3_wrapped", 1'b1, 1'b1, 0, 3, 1'b1, PF0);
      enq(PF0 + 3);
      checkOutput("full_wrapped", 1'b1, 1'b0, 0, 4, 1'b1, PF0);
      issue(PF0, 1'b0);
      commit();
      checkOutput("pre_clear", 1'b1, 1'b1, 0, 3, 1'b1, PF0 + 1);

      // Clear with a concurrent enqueue drops everything.
      applyStimulus(1'b1, PX, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("clear", 1'b0, 1'b1, 0, 0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("clear_hold", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      enq(PG0);
      enq(PG0 + 1);
      enq(PG0 + 2);
      issue(PG0, 1'b0);
      issue(PG0 + 1, 1'b0);
      checkOutput("pre_reset", 1'b1, 1'b1, 2, 3, 1'b1, PG0 + 2);
      applyStimulus(1'b1, PG0 + 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("reset_mid_roll", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      enq(PH);
      checkOutput("post_reset_enq", 1'b1, 1'b1, 0, 1, 1'b1, PH);
      issue(PH, 1'b0);
      commit();
      checkOutput("post_reset_done", 1'b0, 1'b1, 0, 0, 1'b0, '0);

      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d pending required 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
